// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and width helpers for the sequential signed multiplier
//
// Contents:
//   state_t      : controller state encoding (IDLE, RUN, DONE)
//   cnt_width()  : bit counter width for a given operand width
//   max_pos()    : largest positive two's complement value, 2^(w-1) - 1
//   min_neg()    : bit pattern of the most negative value, -2^(w-1); read as an
//                  unsigned number it is also its magnitude 2^(w-1)
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  function automatic logic [63:0] max_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] min_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/conversor_comp2_p.sv
// rtl/conversor_comp2_p.sv - combinational two's complement negator
//
// Ports:
//   x  in  WIDTH  value to negate
//   y  out WIDTH  -x, modulo 2^WIDTH (the most negative value maps to itself)
module conversor_comp2_p #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  assign y = ~x + WIDTH'(1);

endmodule

// File: rtl/mult_secuencial.sv
// rtl/mult_secuencial.sv - shift-add sequential signed multiplier with start/done handshake
//
// Multiplies operand magnitudes over WIDTH cycles, then re-applies the sign and
// flags results that fall outside the signed WIDTH-bit range.
// Optional feature macro: MULT_SAT_EN (saturate m on overflow instead of wrapping).
//
// Ports:
//   clk     in  1      clock, rising edge
//   rst     in  1      synchronous active-high reset
//   start   in  1      request, sampled in IDLE or DONE
//   a, b    in  WIDTH  two's complement operands, captured on an accepted start
//   busy    out 1      engine is running
//   done    out 1      one-cycle pulse, m/of_mul valid from this cycle
//   m       out WIDTH  signed product, held until the next done
//   of_mul  out 1      signed overflow flag for m, held until the next done
module mult_secuencial
  import mult_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] m,
  output logic             of_mul
);

  localparam int CW = cnt_width(WIDTH);
  localparam int AW = 2 * WIDTH;

  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));
  // Overflow limits on the unsigned magnitude product
  localparam logic [AW-1:0]    LIM_POS = AW'(max_pos(WIDTH));
  localparam logic [AW-1:0]    LIM_NEG = AW'(min_neg(WIDTH));

  state_t           state, state_next;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg;
  logic [AW-1:0]    acc, acc_next;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_neg, b_neg, p_neg;
  logic             accept, last;
  logic [WIDTH-1:0] m_wrap, m_next;
  logic             of_next;

  conversor_comp2_p #(.WIDTH(WIDTH)) u_neg_a (.x(a), .y(a_neg));
  conversor_comp2_p #(.WIDTH(WIDTH)) u_neg_b (.x(b), .y(b_neg));
  conversor_comp2_p #(.WIDTH(WIDTH)) u_neg_p (.x(acc_next[WIDTH-1:0]), .y(p_neg));

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // One partial product per cycle; the final product is formed in the same
  // cycle as the last addition so m/of_mul can be registered on entry to DONE.
  always_comb begin
    acc_next = acc;
    if (mag_b[0]) begin
      acc_next = acc + ({{WIDTH{1'b0}}, mag_a} << cnt);
    end
  end

  // Negative results may reach one step further than positive ones.
  assign of_next = neg ? (acc_next > LIM_NEG) : (acc_next > LIM_POS);
  assign m_wrap  = neg ? p_neg : acc_next[WIDTH-1:0];

`ifdef MULT_SAT_EN
  assign m_next = of_next ? (neg ? MIN_NEG : MAX_POS) : m_wrap;
`else
  assign m_next = m_wrap;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      m      <= '0;
      of_mul <= 1'b0;
    end else begin
      if (accept) begin
        // The negator maps -2^(WIDTH-1) onto itself, which read unsigned is
        // exactly its magnitude.
        mag_a <= a[WIDTH-1] ? a_neg : a;
        mag_b <= b[WIDTH-1] ? b_neg : b;
        neg   <= a[WIDTH-1] ^ b[WIDTH-1];
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_next;
        mag_b <= mag_b >> 1;
        cnt   <= cnt + CW'(1);
      end
      if (last) begin
        m      <= m_next;
        of_mul <= of_next;
      end
    end
  end

endmodule
